// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle: column drive and row sense toward the matrix,
// plus the validated key event toward application logic.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column strobe, synchronized row sense,
// whole-keypad snapshot debounce and one key_valid pulse per accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_SCANS);
  localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

  typedef enum logic [1:0] {
    CAND_NONE,
    CAND_KEY,
    CAND_MULTI
  } cand_kind_t;

  typedef struct packed {
    cand_kind_t kind;
    logic [3:0] idx;
  } cand_t;

  logic [3:0]    r_rowMeta;
  logic [3:0]    r_rowSync;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_colIdx;
  logic [15:0]   r_snap;
  cand_t         r_prevCand;
  cand_t         r_stable;
  logic [MW-1:0] r_match;
  logic [3:0]    r_keyCode;
  logic          r_keyValid;

  logic          w_lastDwell;
  logic          w_scanEnd;
  logic [15:0]   w_snapFull;
  cand_t         w_cand;
  logic [MW-1:0] w_nextMatch;
  logic          w_accept;

  assign w_lastDwell = (r_dwell == DWELL_LAST);
  assign w_scanEnd   = w_lastDwell && (r_colIdx == 2'd3);

  // Merge the active column's rows into the snapshot so the column-3 sample
  // is classified in the same cycle it is taken.
  always_comb begin
    w_snapFull = r_snap;
    for (int r = 0; r < 4; r++) begin
      w_snapFull[{2'(r), r_colIdx}] = ~r_rowSync[r];
    end
  end

  always_comb begin
    w_cand.kind = CAND_NONE;
    w_cand.idx  = '0;
    for (int k = 0; k < 16; k++) begin
      if (w_snapFull[k]) begin
        if (w_cand.kind == CAND_NONE) begin
          w_cand.kind = CAND_KEY;
          w_cand.idx  = 4'(k);
        end else begin
          w_cand.kind = CAND_MULTI;
          w_cand.idx  = '0;
        end
      end
    end
  end

  // Non-key candidates carry idx 0, so whole-struct equality is exact.
  always_comb begin
    w_nextMatch = MATCH_ONE;
    if (w_cand == r_prevCand) begin
      w_nextMatch = (r_match == MATCH_MAX) ? r_match : r_match + MATCH_ONE;
    end
    w_accept = w_scanEnd && (w_nextMatch == MATCH_MAX) && (w_cand != r_stable);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rowMeta       <= 4'hF;
      r_rowSync       <= 4'hF;
      r_dwell         <= '0;
      r_colIdx        <= 2'd0;
      r_snap          <= '0;
      r_prevCand.kind <= CAND_NONE;
      r_prevCand.idx  <= '0;
      r_stable.kind   <= CAND_NONE;
      r_stable.idx    <= '0;
      r_match         <= '0;
      r_keyCode       <= 4'd0;
      r_keyValid      <= 1'b0;
    end else begin
      r_rowMeta  <= bus.row;
      r_rowSync  <= r_rowMeta;
      r_keyValid <= 1'b0;
      if (w_lastDwell) begin
        r_dwell  <= '0;
        r_colIdx <= r_colIdx + 2'd1;
        r_snap   <= w_snapFull;
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
      if (w_scanEnd) begin
        r_prevCand <= w_cand;
        r_match    <= w_nextMatch;
      end
      if (w_accept) begin
        r_stable <= w_cand;
        if (w_cand.kind == CAND_KEY) begin
          r_keyCode  <= w_cand.idx;
          r_keyValid <= 1'b1;
        end
      end
    end
  end

  assign bus.col       = ~(4'b0001 << r_colIdx);
  assign bus.key_code  = r_keyCode;
  assign bus.key_valid = r_keyValid;
  assign bus.key_held  = (r_stable.kind == CAND_KEY);

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and is the input-side counterpart of the multiplexed 7-segment driver.
  - The display driver strobes digit selects outward.
  - This block strobes columns outward and reads rows back.
- Debounces whole-keypad snapshots and emits one validated key code per press.
- Sits beside the display driver in the top level and feeds key events to application logic in place of discrete push buttons.

Parameters:
- SCAN_DIV, 50000, clock cycles each column is driven (dwell); must be >= 4.
- DEBOUNCE_SCANS, 4, number of consecutive identical full-scan results required before a result becomes stable; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- row  input  4  keypad rows; asynchronous, active-low (pulled up externally; 0 = pressed key in the active column).
- col  output  4  column drive, active-low one-cold (exactly one bit 0 at all times).
- key_code  output  4  code of the last accepted key = row_index*4 + col_index.
- key_valid  output  1  one-cycle pulse when key_code is updated with a newly accepted key.
- key_held  output  1  high while the stable scan result is a single key.

Behaviour:
- Reset (reset==0 at clk edge):
  - col=4'b1110; key_code=0; key_valid=0; key_held=0.
  - Dwell counter, column index, snapshot, debounce counter and stable state all cleared.
  - Stable state = "none".
  - Reset asserted mid-scan aborts the scan and discards the partial snapshot.
- Synchronizer:
  - row passes through a 2-flop synchronizer; only the synchronized value is used.
- Column scan:
  - Dwell counter counts 0..SCAN_DIV-1 and wraps.
  - The column index advances 0->1->2->3->0 on the wrap.
  - col = ~(1<<index).
- Sampling:
  - Synchronized rows are sampled on dwell count SCAN_DIV-1, the last cycle of each column, to give settle time.
  - Bit (r*4+c) of a 16-bit pressed snapshot = ~row_sync[r] while column c is active.
- Scan classification, at the column-3 sample:
  - Zero bits set: candidate = NONE.
  - Exactly one bit set at position k: candidate = KEY(k).
  - Two or more bits set: candidate = MULTI (ghosting-ambiguous).
- Debounce:
  - If candidate equals the previous scan's candidate, the match counter increments (saturating); otherwise the counter resets to 1.
  - When the counter reaches DEBOUNCE_SCANS and the candidate differs from the stable state, the stable state takes the candidate value.
- Effects of a stable-state change:
  - To KEY(k): key_code=k, key_valid pulses high for exactly the next cycle, key_held=1.
    - This applies even when coming directly from a different KEY(j), i.e. a rollover without release.
  - To NONE: key_held=0, no pulse, key_code retained.
  - To MULTI: key_held=0, no pulse, key_code retained.
    - A subsequent stable single key, including the previously held key, produces a new pulse.
- Held key:
  - A held key that stays stable generates no further pulses (no auto-repeat).
- Latency:
  - From a clean press at the row pins to the key_valid pulse: at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 4 cycles.
  - At least (DEBOUNCE_SCANS-1)*4*SCAN_DIV cycles.
- Bounce rejection:
  - Any scan result differing from its predecessor restarts debouncing.
  - Glitches shorter than one full scan that do not coincide with a sample instant are invisible.
- Width rules:
  - Dwell counter width = clog2(SCAN_DIV).
  - Match counter width = clog2(DEBOUNCE_SCANS+1).
  - The match counter saturates and never wraps.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; the bench keypad model pulls row[r] low when col[c]==0 and key (r,c) is pressed):
- Reset release, no keys -> col sequence 1110,1101,1011,0111 repeats, each held 4 cycles; key_valid never asserts; key_held=0; key_code=0.
- Press key (r=2,c=1) and hold -> exactly one key_valid pulse within 3*16+4 cycles with key_code=9; key_held=1 until release; key_held=0 within 3*16+4 cycles of release; key_code stays 9.
- Key (r=0,c=3) bouncing (toggling every 5 cycles for 40 cycles), then steady -> no pulse during bounce; exactly one pulse with key_code=3 after steady.
- Hold key 5, then add key 6 -> key_held drops to 0 with no pulse; release key 5 while keeping 6 -> one pulse with key_code=6.
- Press key 0, release, press key 0 again -> two separate pulses, each with key_code=0.
- Assert reset mid-dwell while key 15 is held, release reset after 3 cycles -> outputs return to reset values on the reset edge; scan restarts at col=1110; a new pulse with key_code=15 follows after debounce.
